// File: rtl/noc_pkg.sv
// Shared mesh-NoC definitions: port indices, XY route and round-robin pick helpers.
package noc_pkg;

   localparam int NUM_PORTS = 5;
   localparam int CRD_MAX_W = 16;

   typedef logic [2:0] port_idx_t;

   localparam port_idx_t PORT_E = 3'd0;
   localparam port_idx_t PORT_W = 3'd1;
   localparam port_idx_t PORT_N = 3'd2;
   localparam port_idx_t PORT_S = 3'd3;
   localparam port_idx_t PORT_L = 3'd4;

   // Dimension-ordered routing: resolve X first, then Y, then deliver locally.
   function automatic port_idx_t xy_route(
      input logic [CRD_MAX_W-1:0] dx,
      input logic [CRD_MAX_W-1:0] dy,
      input logic [CRD_MAX_W-1:0] xc,
      input logic [CRD_MAX_W-1:0] yc
   );
      port_idx_t res;
      if (dx > xc) begin
         res = PORT_E;
      end else if (dx < xc) begin
         res = PORT_W;
      end else if (dy > yc) begin
         res = PORT_N;
      end else if (dy < yc) begin
         res = PORT_S;
      end else begin
         res = PORT_L;
      end
      return res;
   endfunction

   // Returns {found, index} of the first requester at or after ptr, wrapping 4 -> 0.
   function automatic logic [3:0] rr_pick(
      input logic [NUM_PORTS-1:0] req,
      input port_idx_t            ptr
   );
      logic [3:0] res;
      int         idx;
      res = 4'd0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_PORTS) begin
            idx = idx - NUM_PORTS;
         end else begin
            idx = idx;
         end
         if (!res[3] && req[idx]) begin
            res = {1'b1, port_idx_t'(idx)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   function automatic port_idx_t rr_next(input port_idx_t w);
      return (w >= PORT_L) ? PORT_E : port_idx_t'(w + 3'd1);
   endfunction

endpackage

// File: rtl/noc_fifo.sv
// Single-clock flit FIFO, power-of-two depth, head visible combinationally.
module noc_fifo #(
   parameter int FLIT_W     = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_push,
   input  logic [FLIT_W-1:0] i_data,
   input  logic              i_pop,
   output logic [FLIT_W-1:0] o_head,
   output logic              o_not_empty,
   output logic              o_not_full
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(FIFO_DEPTH);

   logic [FLIT_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_count;

   // Pointer and occupancy tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + PTR_ONE;
         if (i_pop)  r_rptr <= r_rptr + PTR_ONE;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset: occupancy gates every read
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr] <= i_data;
   end

   assign o_head      = r_mem[r_rptr];
   assign o_not_empty = (r_count != '0);
   assign o_not_full  = (r_count < CNT_MAX);

endmodule

// File: rtl/xy_mesh_router.sv
// 5-port XY mesh router: input FIFOs, per-output round-robin, registered outputs.
// Optional forwarded-flit counters on flit_cnt when ROUTER_STATS_EN is defined.
module xy_mesh_router
   import noc_pkg::*;
#(
   parameter int FLIT_W     = 64,
   parameter int FIFO_DEPTH = 4,
   parameter int COORD_W    = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [COORD_W-1:0]          x_cur,
   input  logic [COORD_W-1:0]          y_cur,
   input  logic [NUM_PORTS*FLIT_W-1:0] in_flit,
   input  logic [NUM_PORTS-1:0]        in_valid,
   output logic [NUM_PORTS-1:0]        in_ready,
   output logic [NUM_PORTS*FLIT_W-1:0] out_flit,
   output logic [NUM_PORTS-1:0]        out_valid,
   input  logic [NUM_PORTS-1:0]        out_ready
`ifdef ROUTER_STATS_EN
   ,
   output logic [NUM_PORTS*32-1:0]     flit_cnt
`endif
);

   logic [NUM_PORTS-1:0] w_push;
   logic [NUM_PORTS-1:0] w_pop;
   logic [NUM_PORTS-1:0] w_not_empty;
   logic [NUM_PORTS-1:0] w_not_full;
   logic [FLIT_W-1:0]    w_head [NUM_PORTS];
   port_idx_t            w_route [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_req [NUM_PORTS];
   logic [3:0]           w_pick [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_grant;
   port_idx_t            w_win [NUM_PORTS];
   logic [FLIT_W-1:0]    w_sel_flit [NUM_PORTS];

   logic [FLIT_W-1:0]    r_out_flit [NUM_PORTS];
   logic [NUM_PORTS-1:0] r_out_valid;
   port_idx_t            r_rr [NUM_PORTS];

   assign in_ready = {NUM_PORTS{~reset}} & w_not_full;
   assign w_push   = in_valid & in_ready;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      noc_fifo #(
         .FLIT_W     (FLIT_W),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk         (clk),
         .reset       (reset),
         .i_push      (w_push[p]),
         .i_data      (in_flit[p*FLIT_W +: FLIT_W]),
         .i_pop       (w_pop[p]),
         .o_head      (w_head[p]),
         .o_not_empty (w_not_empty[p]),
         .o_not_full  (w_not_full[p])
      );
      assign out_flit[p*FLIT_W +: FLIT_W] = r_out_flit[p];
   end

   assign out_valid = r_out_valid;

   // Route each FIFO head afresh every cycle, then arbitrate per output
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         w_route[p] = xy_route(
            CRD_MAX_W'(w_head[p][FLIT_W-1 -: COORD_W]),
            CRD_MAX_W'(w_head[p][FLIT_W-1-COORD_W -: COORD_W]),
            CRD_MAX_W'(x_cur),
            CRD_MAX_W'(y_cur));
      end
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            w_req[o][i] = w_not_empty[i] && (w_route[i] == port_idx_t'(o));
         end
         w_pick[o] = rr_pick(w_req[o], r_rr[o]);
         if (w_pick[o][3] && (!r_out_valid[o] || out_ready[o])) begin
            w_grant[o] = 1'b1;
            w_win[o]   = w_pick[o][2:0];
         end else begin
            w_grant[o] = 1'b0;
            w_win[o]   = PORT_E;
         end
         w_sel_flit[o] = w_head[w_win[o]];
      end
      // XY routing sends each head to exactly one output, so pops never collide
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_pop[i] = 1'b0;
         for (int o = 0; o < NUM_PORTS; o++) begin
            w_pop[i] = w_pop[i] | (w_grant[o] && (w_win[o] == port_idx_t'(i)));
         end
      end
   end

   // Output registers and round-robin pointers
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            r_out_flit[o]  <= '0;
            r_out_valid[o] <= 1'b0;
            r_rr[o]        <= PORT_E;
         end
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (w_grant[o]) begin
               r_out_flit[o]  <= w_sel_flit[o];
               r_out_valid[o] <= 1'b1;
               r_rr[o]        <= rr_next(w_win[o]);
            end else if (out_ready[o]) begin
               r_out_valid[o] <= 1'b0;
            end
         end
      end
   end

`ifdef ROUTER_STATS_EN
   logic [NUM_PORTS-1:0][31:0] r_cnt;

   // Count downstream handshakes; 32-bit wrap is intended
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (r_out_valid[o] && out_ready[o]) r_cnt[o] <= r_cnt[o] + 32'd1;
         end
      end
   end

   assign flit_cnt = r_cnt;
`endif

endmodule
